tx_completion_notifier: RTL

- Transmit-side counterpart of the BAR2 doorbell/address receiver.
- When the TX engine frees a huge page (huge_page_free_1/2), this block reports it to the host. It issues one PCIe Memory Write 64 TLP to completed_buffer_address on the TRN transmit interface.
- It shares the TX interface with other engines through a req/grant handshake.

---
 rtl/tx_completion_notifier.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tx_completion_notifier.sv
// Reports released huge pages to the host with a single 64-bit-address MWr TLP
// carrying the running free count and the mask of pages freed since the last report.
module tx_completion_notifier #(
  parameter logic [7:0] TLP_TAG = 8'h00,
  parameter logic [2:0] TLP_TC  = 3'b000
) (
  input  logic        trn_clk,
  input  logic        reset_n,
  input  logic [63:0] completed_buffer_address,
  input  logic        huge_page_free_1,
  input  logic        huge_page_free_2,
  input  logic [15:0] cfg_completer_id,
  output logic        tx_req,
  input  logic        tx_grant,
  output logic        tx_busy,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [5:0]  trn_tbuf_av
);

  typedef enum logic [2:0] {StIdle, StReq, StH0, StH1, StD} state_e;

  state_e      state_q, state_d;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  mask_q, mask_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] free_count_q, free_count_d;
  logic        tx_req_q, tx_req_d;
  logic        tx_busy_q, tx_busy_d;
  logic [63:0] td_q, td_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        snapshot;
  logic        accept;

  // Host reads these dwords little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  assign accept = !src_rdy_n_q && !trn_tdst_rdy_n;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    free_count_d = free_count_q;
    tx_req_d     = tx_req_q;
    tx_busy_d    = tx_busy_q;
    td_d         = td_q;
    sof_n_d      = sof_n_q;
    eof_n_d      = eof_n_q;
    src_rdy_n_d  = src_rdy_n_q;
    snapshot     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((pending_q != 2'b00) && (completed_buffer_address != 64'd0)) begin
          tx_req_d = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (tx_grant && (trn_tbuf_av != 6'd0)) begin
          snapshot     = 1'b1;
          mask_d       = pending_q;
          addr_d       = completed_buffer_address;
          free_count_d = free_count_q + 32'(pending_q[0]) + 32'(pending_q[1]);
          tx_busy_d    = 1'b1;
          td_d         = {1'b0, 7'b11_00000, 1'b0, TLP_TC, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
                          10'd2, cfg_completer_id, TLP_TAG, 4'hF, 4'hF};
          sof_n_d      = 1'b0;
          src_rdy_n_d  = 1'b0;
          state_d      = StH0;
        end
      end
      StH0: begin
        if (accept) begin
          td_d    = {addr_q[63:32], addr_q[31:2], 2'b00};
          sof_n_d = 1'b1;
          state_d = StH1;
        end
      end
      StH1: begin
        if (accept) begin
          td_d    = {bswap32(free_count_q), bswap32({30'd0, mask_q})};
          eof_n_d = 1'b0;
          state_d = StD;
        end
      end
      StD: begin
        if (accept) begin
          td_d        = 64'd0;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
          tx_req_d    = 1'b0;
          tx_busy_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A pulse landing on the snapshot edge must survive the clear.
    if (snapshot) pending_d = 2'b00;
    pending_d = pending_d | {huge_page_free_2, huge_page_free_1};
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pending_q    <= 2'b00;
      mask_q       <= 2'b00;
      addr_q       <= 64'd0;
      free_count_q <= 32'd0;
      tx_req_q     <= 1'b0;
      tx_busy_q    <= 1'b0;
      td_q         <= 64'd0;
      sof_n_q      <= 1'b1;
      eof_n_q      <= 1'b1;
      src_rdy_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      free_count_q <= free_count_d;
      tx_req_q     <= tx_req_d;
      tx_busy_q    <= tx_busy_d;
      td_q         <= td_d;
      sof_n_q      <= sof_n_d;
      eof_n_q      <= eof_n_d;
      src_rdy_n_q  <= src_rdy_n_d;
    end
  end

  assign tx_req         = tx_req_q;
  assign tx_busy        = tx_busy_q;
  assign trn_td         = td_q;
  assign trn_trem_n     = 8'h00;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = src_rdy_n_q;

endmodule
